// File: rtl/expmod_sched_pkg.sv
// Shared types and constants for the expmod scheduler.
package expmod_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } sched_state_t;

  // Moduli below this value give no meaningful result and are rejected.
  localparam int MIN_MODULUS = 2;

endpackage

// File: rtl/expmod_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at
// or after ptr, wrapping from NUM_REQ-1 back to 0.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  input  logic                       en,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx
);
  localparam int IDXW = $clog2(NUM_REQ);

  // Scan from the farthest offset down so the nearest one to ptr wins last.
  always_comb begin
    int k;
    k   = 0;
    gnt = '0;
    idx = '0;
    if (en) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        k = int'(ptr) + i;
        if (k >= NUM_REQ) k = k - NUM_REQ;
        if (req[k]) begin
          gnt    = '0;
          gnt[k] = 1'b1;
          idx    = IDXW'(k);
        end
      end
    end
  end

endmodule

// File: rtl/expmod_scheduler.sv
// Shares one exponent_modulus engine between NUM_REQ requesters.
// Round-robin grant, operands registered at grant, result routed back to the
// owner. Degenerate moduli are answered with an error without using the engine.
// Optional engine watchdog: define EXPMOD_SCHED_TIMEOUT_EN.
module expmod_scheduler
  import expmod_sched_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int KEY_WIDTH      = 32,
  parameter int MSG_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic [NUM_REQ-1:0]                 req_valid_in,
  input  logic [NUM_REQ-1:0][MSG_WIDTH-1:0]  req_value_in,
  input  logic [NUM_REQ-1:0][KEY_WIDTH-1:0]  req_exponent_in,
  input  logic [NUM_REQ-1:0][KEY_WIDTH-1:0]  req_modulus_in,
  output logic [NUM_REQ-1:0]                 req_ready_out,
  output logic [NUM_REQ-1:0]                 resp_valid_out,
  output logic [KEY_WIDTH-1:0]               resp_value_out,
  output logic                               resp_error_out,
  output logic                               eng_ready_out,
  output logic [MSG_WIDTH-1:0]               eng_value_out,
  output logic [KEY_WIDTH-1:0]               eng_exponent_out,
  output logic [KEY_WIDTH-1:0]               eng_modulus_out,
  input  logic                               eng_busy_in,
  input  logic                               eng_valid_in,
  input  logic [KEY_WIDTH-1:0]               eng_value_in
);
  localparam int IDXW = $clog2(NUM_REQ);

  sched_state_t         state;
  logic [IDXW-1:0]      rr_ptr;
  logic [IDXW-1:0]      owner;
  logic [IDXW-1:0]      win_idx;
  logic [NUM_REQ-1:0]   gnt;
  logic [KEY_WIDTH-1:0] result_q;
  logic                 err_q;
  logic                 arb_en;
  logic                 bad_mod;
  logic                 timeout;

  // Grants only in IDLE; held off during reset so outputs read 0 at once.
  assign arb_en = (state == S_IDLE) && !rst_in;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (req_valid_in),
    .ptr (rr_ptr),
    .en  (arb_en),
    .gnt (gnt),
    .idx (win_idx)
  );

  assign req_ready_out  = gnt;
  assign bad_mod        = req_modulus_in[win_idx] < KEY_WIDTH'(MIN_MODULUS);
  assign eng_ready_out  = (state == S_ISSUE) && !eng_busy_in;
  assign resp_value_out = result_q;
  assign resp_error_out = (state == S_RESPOND) && err_q;

  // One-hot result pulse to the requester that owns the transaction.
  always_comb begin
    resp_valid_out = '0;
    if (state == S_RESPOND) resp_valid_out[owner] = 1'b1;
  end

`ifdef EXPMOD_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] wait_cnt;

  // Watchdog counts WAIT cycles; zeroed on the ISSUE->WAIT transition.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)                                 wait_cnt <= '0;
    else if (state == S_ISSUE && !eng_busy_in)  wait_cnt <= '0;
    else if (state == S_WAIT)                   wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout = (state == S_WAIT) && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // Transaction FSM, pointer and operand/result registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state            <= S_IDLE;
      rr_ptr           <= '0;
      owner            <= '0;
      eng_value_out    <= '0;
      eng_exponent_out <= '0;
      eng_modulus_out  <= '0;
      result_q         <= '0;
      err_q            <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|gnt) begin
            owner            <= win_idx;
            rr_ptr           <= (win_idx == IDXW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            eng_value_out    <= req_value_in[win_idx];
            eng_exponent_out <= req_exponent_in[win_idx];
            eng_modulus_out  <= req_modulus_in[win_idx];
            if (bad_mod) begin
              result_q <= '0;
              err_q    <= 1'b1;
              state    <= S_RESPOND;
            end else begin
              state    <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (!eng_busy_in) state <= S_WAIT;
        end
        S_WAIT: begin
          // A result arriving on the timeout cycle takes priority.
          if (eng_valid_in) begin
            result_q <= eng_value_in;
            err_q    <= 1'b0;
            state    <= S_RESPOND;
          end else if (timeout) begin
            result_q <= '0;
            err_q    <= 1'b1;
            state    <= S_RESPOND;
          end
        end
        S_RESPOND: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_expmod_scheduler.sv
// Directed bench for expmod_scheduler: per-cycle vector table plus
// hand-written busy, reset and timeout sequences.
module tb_expmod_scheduler;

  logic              clk_in;
  logic              rst_in;
  logic [1:0]        req_valid_in;
  logic [1:0][15:0]  req_value_in;
  logic [1:0][31:0]  req_exponent_in;
  logic [1:0][31:0]  req_modulus_in;
  logic [1:0]        req_ready_out;
  logic [1:0]        resp_valid_out;
  logic [31:0]       resp_value_out;
  logic              resp_error_out;
  logic              eng_ready_out;
  logic [15:0]       eng_value_out;
  logic [31:0]       eng_exponent_out;
  logic [31:0]       eng_modulus_out;
  logic              eng_busy_in;
  logic              eng_valid_in;
  logic [31:0]       eng_value_in;

  int total = 0;
  int bad   = 0;

  expmod_scheduler #(
    .NUM_REQ(2), .KEY_WIDTH(32), .MSG_WIDTH(16), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_valid_in(req_valid_in), .req_value_in(req_value_in),
    .req_exponent_in(req_exponent_in), .req_modulus_in(req_modulus_in),
    .req_ready_out(req_ready_out), .resp_valid_out(resp_valid_out),
    .resp_value_out(resp_value_out), .resp_error_out(resp_error_out),
    .eng_ready_out(eng_ready_out), .eng_value_out(eng_value_out),
    .eng_exponent_out(eng_exponent_out), .eng_modulus_out(eng_modulus_out),
    .eng_busy_in(eng_busy_in), .eng_valid_in(eng_valid_in),
    .eng_value_in(eng_value_in)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [1:0]  rv;
    logic [31:0] m1;
    logic        busy;
    logic        ev;
    logic [31:0] evv;
    logic [1:0]  x_rdy;
    logic        x_eng;
    logic [31:0] x_mod;
    logic [1:0]  x_rvo;
    logic [31:0] x_val;
    logic        x_err;
  } vec_t;

  vec_t vt [25];

  function automatic vec_t mk(logic [1:0] rv, logic [31:0] m1, logic busy,
                              logic ev, logic [31:0] evv, logic [1:0] x_rdy,
                              logic x_eng, logic [31:0] x_mod, logic [1:0] x_rvo,
                              logic [31:0] x_val, logic x_err);
    vec_t v;
    v.rv = rv; v.m1 = m1; v.busy = busy; v.ev = ev; v.evv = evv;
    v.x_rdy = x_rdy; v.x_eng = x_eng; v.x_mod = x_mod;
    v.x_rvo = x_rvo; v.x_val = x_val; v.x_err = x_err;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %0h want %0h", name, row, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit found;

    // Per-cycle table: inputs applied in the cycle, outputs expected in it.
    //          rv     m1  bsy ev  evv  rdy   eng mod  rvo    val  err
    vt[0]  = mk(2'b01, 77, 0, 0, 0,   2'b01, 0, 0,   2'b00, 0,   0);
    vt[1]  = mk(2'b00, 77, 0, 0, 0,   2'b00, 1, 497, 2'b00, 0,   0);
    vt[2]  = mk(2'b00, 77, 0, 0, 0,   2'b00, 0, 0,   2'b00, 0,   0);
    vt[3]  = mk(2'b00, 77, 0, 1, 445, 2'b00, 0, 0,   2'b00, 0,   0);
    vt[4]  = mk(2'b00, 77, 0, 0, 0,   2'b00, 0, 0,   2'b01, 445, 0);
    vt[5]  = mk(2'b10, 1,  0, 0, 0,   2'b10, 0, 0,   2'b00, 445, 0);
    vt[6]  = mk(2'b00, 77, 0, 0, 0,   2'b00, 0, 0,   2'b10, 0,   1);
    vt[7]  = mk(2'b00, 77, 0, 1, 999, 2'b00, 0, 0,   2'b00, 0,   0);
    vt[8]  = mk(2'b11, 77, 0, 0, 0,   2'b01, 0, 0,   2'b00, 0,   0);
    vt[9]  = mk(2'b11, 77, 0, 0, 0,   2'b00, 1, 497, 2'b00, 0,   0);
    vt[10] = mk(2'b11, 77, 0, 1, 100, 2'b00, 0, 0,   2'b00, 0,   0);
    vt[11] = mk(2'b11, 77, 0, 0, 0,   2'b00, 0, 0,   2'b01, 100, 0);
    vt[12] = mk(2'b11, 77, 0, 0, 0,   2'b10, 0, 0,   2'b00, 100, 0);
    vt[13] = mk(2'b11, 77, 0, 0, 0,   2'b00, 1, 77,  2'b00, 100, 0);
    vt[14] = mk(2'b11, 77, 0, 1, 200, 2'b00, 0, 0,   2'b00, 100, 0);
    vt[15] = mk(2'b11, 77, 0, 0, 0,   2'b00, 0, 0,   2'b10, 200, 0);
    vt[16] = mk(2'b11, 77, 0, 0, 0,   2'b01, 0, 0,   2'b00, 200, 0);
    vt[17] = mk(2'b11, 77, 0, 0, 0,   2'b00, 1, 497, 2'b00, 200, 0);
    vt[18] = mk(2'b11, 77, 0, 1, 300, 2'b00, 0, 0,   2'b00, 200, 0);
    vt[19] = mk(2'b11, 77, 0, 0, 0,   2'b00, 0, 0,   2'b01, 300, 0);
    vt[20] = mk(2'b11, 77, 0, 0, 0,   2'b10, 0, 0,   2'b00, 300, 0);
    vt[21] = mk(2'b00, 77, 0, 0, 0,   2'b00, 1, 77,  2'b00, 300, 0);
    vt[22] = mk(2'b00, 77, 0, 1, 400, 2'b00, 0, 0,   2'b00, 300, 0);
    vt[23] = mk(2'b00, 77, 0, 0, 0,   2'b00, 0, 0,   2'b10, 400, 0);
    vt[24] = mk(2'b00, 77, 0, 0, 0,   2'b00, 0, 0,   2'b00, 400, 0);

    rst_in = 1'b1;
    req_valid_in = 2'b11;
    req_value_in[0] = 16'd4;  req_exponent_in[0] = 32'd13; req_modulus_in[0] = 32'd497;
    req_value_in[1] = 16'd9;  req_exponent_in[1] = 32'd3;  req_modulus_in[1] = 32'd77;
    eng_busy_in = 1'b0; eng_valid_in = 1'b0; eng_value_in = '0;

    // Reset state with requests pending.
    repeat (3) tick();
    chk("rst_ready", 0, req_ready_out, 0);
    chk("rst_resp", 0, resp_valid_out, 0);
    chk("rst_value", 0, resp_value_out, 0);
    chk("rst_err", 0, resp_error_out, 0);
    chk("rst_eng", 0, eng_ready_out, 0);
    chk("rst_emod", 0, eng_modulus_out, 0);
    rst_in = 1'b0;

    // Single request, bad modulus, stray strobe, contention.
    for (int i = 0; i < 25; i++) begin
      req_valid_in      = vt[i].rv;
      req_modulus_in[1] = vt[i].m1;
      eng_busy_in       = vt[i].busy;
      eng_valid_in      = vt[i].ev;
      eng_value_in      = vt[i].evv;
      #1;
      chk("ready", i, req_ready_out, vt[i].x_rdy);
      chk("eng_ready", i, eng_ready_out, vt[i].x_eng);
      chk("resp_valid", i, resp_valid_out, vt[i].x_rvo);
      chk("resp_value", i, resp_value_out, vt[i].x_val);
      chk("resp_err", i, resp_error_out, vt[i].x_err);
      if (vt[i].x_eng) chk("eng_mod", i, eng_modulus_out, vt[i].x_mod);
      tick();
    end
    eng_valid_in = 1'b0;

    // Busy engine: issue waits, operands stay as latched at accept.
    req_valid_in = 2'b01; eng_busy_in = 1'b1;
    #1 chk("busy_acc", 0, req_ready_out, 2'b01);
    tick();
    req_valid_in = 2'b00; req_value_in[0] = 16'd55;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("busy_hold", c, eng_ready_out, 0);
      chk("busy_ops", c, eng_value_out, 4);
      tick();
    end
    eng_busy_in = 1'b0;
    #1;
    chk("busy_issue", 0, eng_ready_out, 1);
    chk("busy_ops_issue", 0, eng_value_out, 4);
    chk("busy_exp_issue", 0, eng_exponent_out, 13);
    tick();
    eng_valid_in = 1'b1; eng_value_in = 32'd123;
    #1 chk("busy_wait", 0, resp_valid_out, 0);
    tick();
    eng_valid_in = 1'b0;
    #1;
    chk("busy_resp", 0, resp_valid_out, 2'b01);
    chk("busy_val", 0, resp_value_out, 123);
    tick();
    req_value_in[0] = 16'd4;

    // Reset mid-WAIT: transaction dropped, pointer back to 0.
    req_valid_in = 2'b10;
    #1 chk("rw_acc", 0, req_ready_out, 2'b10);
    tick();
    req_valid_in = 2'b00;
    #1 chk("rw_issue", 0, eng_ready_out, 1);
    tick();
    req_valid_in = 2'b11;
    #2 rst_in = 1'b1;
    #1;
    chk("rw_ready", 0, req_ready_out, 0);
    chk("rw_resp", 0, resp_valid_out, 0);
    chk("rw_val", 0, resp_value_out, 0);
    chk("rw_eval", 0, eng_value_out, 0);
    chk("rw_emod", 0, eng_modulus_out, 0);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rw_noresp", c, resp_valid_out, 0);
    end
    rst_in = 1'b0;
    #1 chk("rw_regrant", 0, req_ready_out, 2'b01);
    tick();
    req_valid_in = 2'b00;
    #1 chk("rw_reissue", 0, eng_ready_out, 1);
    tick();
    eng_valid_in = 1'b1; eng_value_in = 32'd9;
    tick();
    eng_valid_in = 1'b0;
    #1;
    chk("rw_resp2", 0, resp_valid_out, 2'b01);
    chk("rw_val2", 0, resp_value_out, 9);
    tick();

`ifdef EXPMOD_SCHED_TIMEOUT_EN
    // Timeout: engine never answers.
    req_valid_in = 2'b10;
    #1 chk("to_acc", 0, req_ready_out, 2'b10);
    tick();
    req_valid_in = 2'b00;
    #1 chk("to_issue", 0, eng_ready_out, 1);
    tick();
    n = 0; found = 0;
    while (n < 40 && !found) begin
      #1;
      if (resp_valid_out != 2'b00) found = 1;
      else begin tick(); n++; end
    end
    chk("to_latency", 0, n, 16);
    chk("to_resp", 0, resp_valid_out, 2'b10);
    chk("to_err", 0, resp_error_out, 1);
    chk("to_val", 0, resp_value_out, 0);
    tick();
    eng_valid_in = 1'b1; eng_value_in = 32'd77;
    #1 chk("to_stray", 0, resp_valid_out, 0);
    tick();
    eng_valid_in = 1'b0;
    #1 chk("to_stray2", 0, resp_valid_out, 0);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/expmod_scheduler.md
# expmod_scheduler

Shares one `exponent_modulus` engine between `NUM_REQ` independent requesters, for example the UART command path and an on-chip key-generation path. It uses round-robin arbitration. Operands are registered at grant, the engine is started, and the engine result is routed back to the owning requester. It sits between the requester front-ends and the single expmod instance in the top level. Degenerate moduli are rejected without occupying the engine.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters (≥2).
- `KEY_WIDTH`, 32: exponent, modulus and result width.
- `MSG_WIDTH`, 16: message value width.
- `TIMEOUT_CYCLES`, 65536: engine watchdog limit. Used only with `EXPMOD_SCHED_TIMEOUT_EN`.

Ports:
- `clk_in`  in  1  single clock.
- `rst_in`  in  1  reset; asynchronous, active-high.
- `req_valid_in`  in  `NUM_REQ`  per-requester request; held with operands until accepted.
- `req_value_in`  in  `NUM_REQ`×`MSG_WIDTH`  message operand.
- `req_exponent_in`  in  `NUM_REQ`×`KEY_WIDTH`  exponent operand.
- `req_modulus_in`  in  `NUM_REQ`×`KEY_WIDTH`  modulus operand.
- `req_ready_out`  out  `NUM_REQ`  one-hot, 1-cycle accept pulse.
- `resp_valid_out`  out  `NUM_REQ`  one-hot, 1-cycle result pulse to the owner.
- `resp_value_out`  out  `KEY_WIDTH`  result; valid only with `resp_valid_out`.
- `resp_error_out`  out  1  qualifies `resp_valid_out`; 1 = rejected or timed out.
- `eng_ready_out`  out  1  1-cycle start pulse to the engine's `ready_in`.
- `eng_value_out`, `eng_exponent_out`, `eng_modulus_out`  out  `MSG_WIDTH`/`KEY_WIDTH`/`KEY_WIDTH`  registered operands to the engine.
- `eng_busy_in`  in  1  engine busy.
- `eng_valid_in`  in  1  engine result strobe.
- `eng_value_in`  in  `KEY_WIDTH`  engine result.

## Operation
- FSM states:
  - IDLE: round-robin select among `req_valid_in`, starting at pointer `rr_ptr`. On a winner: pulse `req_ready_out[w]`, latch the operands and owner `w`, and set `rr_ptr` = (w+1) mod `NUM_REQ`.
    - If the latched modulus is < 2: go to RESPOND with error.
    - Otherwise: go to ISSUE.
  - ISSUE: wait while `eng_busy_in`=1. When it is 0, pulse `eng_ready_out` for one cycle and go to WAIT.
  - WAIT: on `eng_valid_in`, register `eng_value_in` and go to RESPOND with error=0.
  - RESPOND: pulse `resp_valid_out[owner]` for one cycle with `resp_value_out` and `resp_error_out`, then go to IDLE.
- Error response: `resp_value_out`=0, `resp_error_out`=1.
- Ignored inputs:
  - `eng_valid_in` outside WAIT.
  - `req_valid_in` outside IDLE.
  - A requester dropping valid before grant: no effect, and `rr_ptr` does not advance.
- Only one transaction is in flight at a time. Requests from other requesters simply stay pending.
- `resp_value_out` holds its last value between pulses.

## Timing
- Reset values: all outputs 0, state IDLE, `rr_ptr`=0, operand registers 0.
- Reset asserted mid-transaction:
  - The transaction is dropped and no response is issued.
  - The engine shares `rst_in`, so no stale `eng_valid_in` can follow.
- Accept: `req_ready_out` is asserted in the IDLE cycle where `req_valid_in` is sampled high. The requester may change operands on the next cycle.
- `eng_ready_out` fires 1 cycle after accept when `eng_busy_in`=0.
- `resp_valid_out` fires 1 cycle after the `eng_valid_in` cycle.
- Rejected request: `resp_valid_out` fires 1 cycle after accept.
- Back-to-back: the next grant can occur in the cycle after `resp_valid_out`, giving a minimum of 2 idle-to-idle cycles of scheduler overhead per transaction.
- Simultaneous requests: grant goes to the first asserted index at or after `rr_ptr`, wrapping from `NUM_REQ`-1 to 0.

## Configuration
- `EXPMOD_SCHED_TIMEOUT_EN` defined:
  - A counter runs in WAIT, cleared on entry.
  - When it reaches `TIMEOUT_CYCLES`-1 without `eng_valid_in`: go to RESPOND with error.
  - An `eng_valid_in` arriving in the same cycle as the timeout wins, giving a normal response.
  - Late engine strobes are ignored by the WAIT-only rule.
- Undefined: WAIT lasts indefinitely, no counter logic is generated, and `TIMEOUT_CYCLES` is unused.

## Structure
- Package `expmod_sched_pkg` holds:
  - the state enum `sched_state_t` (IDLE, ISSUE, WAIT, RESPOND);
  - the constant `MIN_MODULUS` = 2.
- Sub-module `rr_arbiter`, parameterised by `NUM_REQ`:
  - inputs: request vector, pointer, enable;
  - outputs: one-hot grant and winner index;
  - combinational.
- The scheduler owns the pointer register and the FSM.

## Test plan
- Single request: requester 0 sends value=4, exp=13, mod=497 → one `eng_ready_out` pulse; with the engine model returning 445, `resp_valid_out`=01, value=445, error=0.
- Contention: both requesters valid from reset → grants in order 0, 1, 0, 1 over 4 transactions; each response goes only to the granted index.
- Bad modulus: requester 1 sends mod=1 → `eng_ready_out` never pulses; `resp_valid_out`=10 one cycle after accept with error=1, value=0.
- Busy engine: `eng_busy_in` held high for 10 cycles after accept → `eng_ready_out` is delayed until the first cycle where busy is low; the operands are unchanged.
- Reset mid-WAIT: assert `rst_in` asynchronously during WAIT → all outputs 0 immediately; no `resp_valid_out`; a new request is accepted normally afterward.
- Timeout (macro defined, `TIMEOUT_CYCLES`=16): the engine never returns → error response 16 cycles after entering WAIT; a stray `eng_valid_in` afterward is ignored.
